ttc_irq_collect: RTL and testbench
==================================

TTC_IRQ_COLLECT -- requirements
Module: ttc_irq_collect

Interface
REQ-001 SHALL take parameter SYNC_STAGES, default 2, number of synchroniser flops per event input (legal range 2..3).
REQ-002 SHALL have port n_p_reset  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port pclk  input  1  clock; all state in this block is clocked by pclk.
REQ-004 SHALL have port pwdata  input  32  APB write data; only bits [5:0] are used.
REQ-005 SHALL have port intr_en_reg_sel  input  1  single-cycle write strobe for this timer's interrupt enable register.
REQ-006 SHALL have port clear_interrupt  input  1  single-cycle strobe marking the access phase of an interrupt-register read.
REQ-007 SHALL have port interval_evt  input  1  interval-reached level from the counter, asynchronous to pclk.
REQ-008 SHALL have port match_evt  input  3  match 1..3 levels from the counter, bit 0 = match 1, asynchronous to pclk.
REQ-009 SHALL have port overflow_evt  input  1  counter overflow level, asynchronous to pclk.
REQ-010 SHALL have port event_ovf_evt  input  1  event-timer overflow level, asynchronous to pclk.
REQ-011 SHALL have port interrupt_reg  output  6  sticky status: [0] interval, [3:1] match 1..3, [4] overflow, [5] event overflow.
REQ-012 SHALL have port interrupt_en_reg  output  6  per-bit enable, same bit map as interrupt_reg.
REQ-013 SHALL have port interrupt  output  1  timer interrupt request, active-high.

Function
REQ-014 SHALL pass each of the 6 event inputs through a SYNC_STAGES-deep synchroniser, then a rising-edge detector (registered previous value).
REQ-015 SHALL generate a one-pclk set pulse per bit on each synchronised 0->1 transition; a held-high level SHALL NOT re-set a bit after it is cleared.
REQ-016 SHALL, with SYNC_STAGES=2, show the status bit set at the 3rd pclk rising edge after the input rises (input stable across setup time).
REQ-017 SHALL hold status bits sticky until cleared: next interrupt_reg = (clear_interrupt ? 0 : interrupt_reg) | set_pulses.
REQ-018 SHALL let set win over clear: an event whose set pulse coincides with clear_interrupt remains set after that edge.
REQ-019 SHALL set status bits regardless of interrupt_en_reg; enables gate only the interrupt output.
REQ-020 SHALL load interrupt_en_reg <= pwdata[5:0] on the edge where intr_en_reg_sel=1, and otherwise hold it.
REQ-021 SHALL drive interrupt as a register: next interrupt = |(next interrupt_reg & next interrupt_en_reg), so that it tracks status and enable updates with zero extra lag.
REQ-022 SHALL drop interrupt on the same edge that clears the last enabled pending bit, or that disables it.
REQ-023 SHALL take no action on multiple simultaneous set pulses other than setting all of the corresponding bits.
REQ-024 SHALL treat clear_interrupt and intr_en_reg_sel in the same cycle independently; both SHALL take effect.
REQ-025 SHALL leave no SYNC_STAGES value combinationally dependent on an asynchronous input.

Reset
REQ-026 SHALL, while n_p_reset=0, force interrupt_reg=6'h00, interrupt_en_reg=6'h00, interrupt=0, and all synchroniser and edge-detect flops to 0.
REQ-027 SHALL, after reset release with an event input already high, register one set pulse for it (0->1 seen post-reset).
REQ-028 SHALL discard any pending set pulse or enable write on assertion of reset mid-operation.

Structure
REQ-029 SHALL place bit-index constants (IRQ_INTERVAL=0, IRQ_MATCH1..3=1..3, IRQ_OVF=4, IRQ_EVT_OVF=5) and IRQ_WIDTH=6 in shared package ttc_irq_pkg.
REQ-030 SHALL implement the synchroniser plus edge detector as one sub-module, ttc_irq_sync, instantiated per event bit.
REQ-031 SHALL contain no other sub-modules; the status, enable and output logic SHALL live in ttc_irq_collect.

Verification
REQ-032 Stimulus: enable=6'h01, interval_evt rises at T -> interrupt_reg=6'h01 at edge T+3 and interrupt=1 at the same edge.
REQ-033 Stimulus: enable=6'h00, match_evt=3'b010 rises -> interrupt_reg=6'h04 and interrupt=0; then write pwdata=32'h04 -> interrupt=1 on that edge.
REQ-034 Stimulus: pending 6'h10, clear_interrupt pulse -> interrupt_reg=6'h00 and interrupt=0 on that edge; held-high overflow_evt does not re-set the bit.
REQ-035 Stimulus: clear_interrupt coincides with a set pulse for bit 5, old value 6'h01 -> interrupt_reg=6'h20.
REQ-036 Stimulus: all six events rise together -> interrupt_reg=6'h3F; n_p_reset pulsed low -> all outputs 0 immediately (asynchronous).
REQ-037 Stimulus: rerun REQ-032 with SYNC_STAGES=3 -> status bit sets at edge T+4.

Source files
------------

// File: rtl/ttc_irq_pkg.sv
// Shared bit map and widths for the timer interrupt collector.
// Bit positions match the interrupt status/enable register layout.
package ttc_irq_pkg;

  localparam int IRQ_WIDTH    = 6;
  localparam int IRQ_INTERVAL = 0;
  localparam int IRQ_MATCH1   = 1;
  localparam int IRQ_MATCH2   = 2;
  localparam int IRQ_MATCH3   = 3;
  localparam int IRQ_OVF      = 4;
  localparam int IRQ_EVT_OVF  = 5;

  typedef logic [IRQ_WIDTH-1:0] irq_vec_t;

endpackage

// File: rtl/ttc_irq_sync.sv
// Multi-flop synchroniser plus rising-edge detector for one asynchronous event level.
// o_set is a one-pclk pulse driven only from flops, never from i_evt directly.
module ttc_irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic pclk,
  input  logic n_p_reset,
  input  logic i_evt,
  output logic o_set
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge pclk or negedge n_p_reset) begin
    if (!n_p_reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_evt};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  // Level held high after a clear produces no further pulse: only 0->1 counts.
  assign o_set = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/ttc_irq_collect.sv
// Collects six timer events into sticky status bits, holds the enable mask and
// drives a registered interrupt that follows next-state status and enable.
module ttc_irq_collect
  import ttc_irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 n_p_reset,
  input  logic                 pclk,
  input  logic [31:0]          pwdata,
  input  logic                 intr_en_reg_sel,
  input  logic                 clear_interrupt,
  input  logic                 interval_evt,
  input  logic [2:0]           match_evt,
  input  logic                 overflow_evt,
  input  logic                 event_ovf_evt,
  output logic [IRQ_WIDTH-1:0] interrupt_reg,
  output logic [IRQ_WIDTH-1:0] interrupt_en_reg,
  output logic                 interrupt
);

  irq_vec_t w_evt;
  irq_vec_t w_set;
  irq_vec_t w_status_nxt;
  irq_vec_t w_en_nxt;
  irq_vec_t r_status;
  irq_vec_t r_en;
  logic     r_irq;
  logic     w_unused_pwdata;

  assign w_evt[IRQ_INTERVAL]          = interval_evt;
  assign w_evt[IRQ_MATCH3:IRQ_MATCH1] = match_evt;
  assign w_evt[IRQ_OVF]               = overflow_evt;
  assign w_evt[IRQ_EVT_OVF]           = event_ovf_evt;

  assign w_unused_pwdata = |pwdata[31:IRQ_WIDTH];

  for (genvar g = 0; g < IRQ_WIDTH; g++) begin : g_sync
    ttc_irq_sync #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
      .pclk      (pclk),
      .n_p_reset (n_p_reset),
      .i_evt     (w_evt[g]),
      .o_set     (w_set[g])
    );
  end

  // Set is OR-ed after the clear so a coincident event survives the clear.
  assign w_status_nxt = (clear_interrupt ? '0 : r_status) | w_set;
  assign w_en_nxt     = intr_en_reg_sel ? pwdata[IRQ_WIDTH-1:0] : r_en;

  always_ff @(posedge pclk or negedge n_p_reset) begin
    if (!n_p_reset) begin
      r_status <= '0;
      r_en     <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_status <= w_status_nxt;
      r_en     <= w_en_nxt;
      r_irq    <= |(w_status_nxt & w_en_nxt);
    end
  end

  assign interrupt_reg    = r_status;
  assign interrupt_en_reg = r_en;
  assign interrupt        = r_irq;

endmodule

// File: tb/tb_ttc_irq_collect.sv
// Drives two collectors (2- and 3-stage synchronisers) with shared stimulus and
// compares both against a sample-history reference model.
module tb_ttc_irq_collect;

  logic        pclk = 1'b0;
  logic        n_p_reset = 1'b0;
  logic [31:0] pwdata = '0;
  logic        intr_en_reg_sel = 1'b0;
  logic        clear_interrupt = 1'b0;
  logic        interval_evt = 1'b0;
  logic [2:0]  match_evt = '0;
  logic        overflow_evt = 1'b0;
  logic        event_ovf_evt = 1'b0;

  logic [5:0]  st2, en2, st3, en3;
  logic        irq2, irq3;

  int checks = 0;
  int failures = 0;

  // Reference state: h[0] is the input vector sampled at the latest edge.
  logic [5:0] h [0:4];
  logic [5:0] m_st2, m_st3, m_en;
  logic       m_irq2, m_irq3;

  always #5 pclk = ~pclk;

  ttc_irq_collect #(.SYNC_STAGES(2)) dut2 (
    .n_p_reset(n_p_reset), .pclk(pclk), .pwdata(pwdata),
    .intr_en_reg_sel(intr_en_reg_sel), .clear_interrupt(clear_interrupt),
    .interval_evt(interval_evt), .match_evt(match_evt),
    .overflow_evt(overflow_evt), .event_ovf_evt(event_ovf_evt),
    .interrupt_reg(st2), .interrupt_en_reg(en2), .interrupt(irq2)
  );

  ttc_irq_collect #(.SYNC_STAGES(3)) dut3 (
    .n_p_reset(n_p_reset), .pclk(pclk), .pwdata(pwdata),
    .intr_en_reg_sel(intr_en_reg_sel), .clear_interrupt(clear_interrupt),
    .interval_evt(interval_evt), .match_evt(match_evt),
    .overflow_evt(overflow_evt), .event_ovf_evt(event_ovf_evt),
    .interrupt_reg(st3), .interrupt_en_reg(en3), .interrupt(irq3)
  );

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) h[i] = '0;
    m_st2 = '0; m_st3 = '0; m_en = '0; m_irq2 = 1'b0; m_irq3 = 1'b0;
  endtask

  // A stage-S synchroniser sees the sample taken S-1 edges ago; a rise is
  // registered in status one edge later, so it compares samples S and S+1 back.
  task automatic model_edge(input logic [5:0] evt, input logic clr, input logic sel,
                            input logic [5:0] wd);
    for (int i = 4; i > 0; i--) h[i] = h[i-1];
    h[0] = evt;
    m_st2 = (clr ? 6'h00 : m_st2) | (h[2] & ~h[3]);
    m_st3 = (clr ? 6'h00 : m_st3) | (h[3] & ~h[4]);
    if (sel) m_en = wd;
    m_irq2 = |(m_st2 & m_en);
    m_irq3 = |(m_st3 & m_en);
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_st2"}, st2, m_st2);
    check({tag, "_en2"}, en2, m_en);
    check({tag, "_irq2"}, {5'd0, irq2}, {5'd0, m_irq2});
    check({tag, "_st3"}, st3, m_st3);
    check({tag, "_en3"}, en3, m_en);
    check({tag, "_irq3"}, {5'd0, irq3}, {5'd0, m_irq3});
  endtask

  // Entered and left at a falling edge.
  task automatic step(input string tag, input logic [5:0] evt, input logic clr,
                      input logic sel, input logic [31:0] wd);
    {event_ovf_evt, overflow_evt, match_evt, interval_evt} = evt;
    clear_interrupt = clr;
    intr_en_reg_sel = sel;
    pwdata = wd;
    @(posedge pclk);
    model_edge(evt, clr, sel, wd[5:0]);
    #1;
    compare_all(tag);
    @(negedge pclk);
  endtask

  task automatic do_reset(input string tag);
    n_p_reset = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    @(negedge pclk);
    clear_interrupt = 1'b0;
    intr_en_reg_sel = 1'b0;
    n_p_reset = 1'b1;
  endtask

  logic [5:0] evt_r;

  initial begin
    @(negedge pclk);
    do_reset("reset");

    // Interval with enable: 2-stage sets at edge T+3, 3-stage at T+4.
    step("en01", 6'h00, 1'b0, 1'b1, 32'h0000_0001);
    step("int_e1", 6'h01, 1'b0, 1'b0, 32'h0);
    step("int_e2", 6'h01, 1'b0, 1'b0, 32'h0);
    check("int_not_yet", st2, 6'h00);
    step("int_e3", 6'h01, 1'b0, 1'b0, 32'h0);
    check("int_s2_t3", st2, 6'h01);
    check("int_s2_irq", {5'd0, irq2}, 6'h01);
    check("int_s3_t3", st3, 6'h00);
    step("int_e4", 6'h01, 1'b0, 1'b0, 32'h0);
    check("int_s3_t4", st3, 6'h01);

    // Coincident clear and bit-5 set: status becomes 6'h20 on the 2-stage part.
    step("b5_e1", 6'h21, 1'b0, 1'b0, 32'h0);
    step("b5_e2", 6'h21, 1'b0, 1'b0, 32'h0);
    step("b5_e3", 6'h21, 1'b1, 1'b0, 32'h0);
    check("clr_vs_set", st2, 6'h20);
    for (int i = 0; i < 3; i++) step("b5_hold", 6'h21, 1'b0, 1'b0, 32'h0);

    @(negedge pclk);
    do_reset("rst2");

    // Match 2 with enables off, then enable write raises the interrupt on that edge.
    step("en00", 6'h00, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 4; i++) step("m2", 6'h04, 1'b0, 1'b0, 32'h0);
    check("m2_status", st2, 6'h04);
    check("m2_noirq", {5'd0, irq2}, 6'h00);
    step("m2_en", 6'h04, 1'b0, 1'b1, 32'hFFFF_FF04);
    check("m2_irq_on_write", {5'd0, irq2}, 6'h01);

    // Overflow pending then cleared; held-high level must not re-set it.
    step("en10", 6'h04, 1'b1, 1'b1, 32'h0000_0010);
    for (int i = 0; i < 4; i++) step("ovf", 6'h14, 1'b0, 1'b0, 32'h0);
    check("ovf_pending", st2, 6'h10);
    step("ovf_clr", 6'h14, 1'b1, 1'b0, 32'h0);
    check("ovf_cleared", st2, 6'h00);
    check("ovf_irq_drop", {5'd0, irq2}, 6'h00);
    for (int i = 0; i < 3; i++) step("ovf_held", 6'h14, 1'b0, 1'b0, 32'h0);
    check("ovf_no_reset", st2, 6'h00);

    // All six together, then asynchronous reset mid-operation.
    step("all_lo", 6'h00, 1'b1, 1'b1, 32'h0000_003F);
    for (int i = 0; i < 4; i++) step("all", 6'h3F, 1'b0, 1'b0, 32'h0);
    check("all_set", st3, 6'h3F);
    step("all_wr", 6'h3F, 1'b0, 1'b1, 32'h0000_0015);
    #2;
    do_reset("async_rst");

    // Inputs high at release produce exactly one set pulse each.
    for (int i = 0; i < 5; i++) step("post_rst", 6'h3F, 1'b0, 1'b0, 32'h0);
    check("post_rst_set", st2, 6'h3F);

    // Randomised traffic with sparse toggles, strobes and occasional resets.
    evt_r = '0;
    for (int n = 0; n < 300; n++) begin
      for (int b = 0; b < 6; b++)
        if ($urandom_range(0, 5) == 0) evt_r[b] = ~evt_r[b];
      if ($urandom_range(0, 60) == 0) begin
        do_reset("rnd_rst");
      end else begin
        step("rnd", evt_r, ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
             $urandom);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
